// File: rtl/div_ctrl.sv
// Control stage in front of the iterative RV64M divider: operand extension,
// special-case resolution, sign correction and result holding.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  inst_opcode,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic        flush,
    output logic        div_start,
    output logic        div_kill,
    output logic [63:0] div_op1,
    output logic [63:0] div_op2,
    input  logic        div_done,
    input  logic [63:0] div_quot,
    input  logic [63:0] div_rem,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    localparam logic [7:0] INST_DIV   = 8'h50;
    localparam logic [7:0] INST_DIVU  = 8'h51;
    localparam logic [7:0] INST_DIVW  = 8'h52;
    localparam logic [7:0] INST_DIVUW = 8'h53;
    localparam logic [7:0] INST_REM   = 8'h54;
    localparam logic [7:0] INST_REMU  = 8'h55;
    localparam logic [7:0] INST_REMW  = 8'h56;
    localparam logic [7:0] INST_REMUW = 8'h57;

    localparam logic [63:0] MIN_D = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MIN_W = 64'hFFFF_FFFF_8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        word_q, word_d;
    logic        rem_q, rem_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        start_q, start_d;
    logic [63:0] op1_q, op1_d;
    logic [63:0] op2_q, op2_d;
    logic [63:0] data_q, data_d;

    logic        is_signed;
    logic        is_word;
    logic        is_rem;
    logic [63:0] opa;
    logic [63:0] opb;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_mag;
    logic [63:0] b_mag;
    logic        div_zero;
    logic        overflow;
    logic [63:0] special_res;
    logic [63:0] quot_fix;
    logic [63:0] rem_fix;
    logic [63:0] calc_res;

    function automatic logic [63:0] word_fix(input logic w, input logic [63:0] v);
        word_fix = w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    always_comb begin
        is_signed = (inst_opcode == INST_DIV)  || (inst_opcode == INST_REM) ||
                    (inst_opcode == INST_DIVW) || (inst_opcode == INST_REMW);
        is_word   = (inst_opcode == INST_DIVW) || (inst_opcode == INST_DIVUW) ||
                    (inst_opcode == INST_REMW) || (inst_opcode == INST_REMUW);
        is_rem    = (inst_opcode == INST_REM)  || (inst_opcode == INST_REMU) ||
                    (inst_opcode == INST_REMW) || (inst_opcode == INST_REMUW);

        if (is_word) begin
            opa = is_signed ? {{32{src1[31]}}, src1[31:0]} : {32'b0, src1[31:0]};
            opb = is_signed ? {{32{src2[31]}}, src2[31:0]} : {32'b0, src2[31:0]};
        end else begin
            opa = src1;
            opb = src2;
        end

        a_neg = is_signed & opa[63];
        b_neg = is_signed & opb[63];
        a_mag = a_neg ? (~opa + 64'd1) : opa;
        b_mag = b_neg ? (~opb + 64'd1) : opb;

        div_zero = (opb == 64'd0);
        overflow = is_signed && (opb == {64{1'b1}}) &&
                   (opa == (is_word ? MIN_W : MIN_D));

        // Divide-by-zero wins over overflow; both are exclusive anyway since b differs.
        if (div_zero) begin
            special_res = is_rem ? opa : {64{1'b1}};
        end else begin
            special_res = is_rem ? 64'd0 : opa;
        end
        special_res = word_fix(is_word, special_res);

        quot_fix = q_neg_q ? (~div_quot + 64'd1) : div_quot;
        rem_fix  = r_neg_q ? (~div_rem + 64'd1) : div_rem;
        calc_res = word_fix(word_q, rem_q ? rem_fix : quot_fix);
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        rem_d   = rem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        start_d = 1'b0;
        op1_d   = op1_q;
        op2_d   = op2_q;
        data_d  = data_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_d  = is_word;
                        rem_d   = is_rem;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        if (div_zero || overflow) begin
                            data_d  = special_res;
                            state_d = ST_DONE;
                        end else begin
                            op1_d   = a_mag;
                            op2_d   = b_mag;
                            start_d = 1'b1;
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    // A done seen alongside start belongs to a previously killed run.
                    if (div_done && !start_q) begin
                        data_d  = calc_res;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            word_q  <= 1'b0;
            rem_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            start_q <= 1'b0;
            op1_q   <= 64'd0;
            op2_q   <= 64'd0;
            data_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            rem_q   <= rem_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            start_q <= start_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = data_q;
    assign div_start = start_q;
    assign div_kill  = flush && (state_q == ST_CALC);
    assign div_op1   = op1_q;
    assign div_op2   = op2_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: bench-side divider model plus a queue scoreboard
// of expected results.
`timescale 1ns/1ps
module tb_div_ctrl;

    localparam logic [7:0] INST_DIV   = 8'h50;
    localparam logic [7:0] INST_DIVU  = 8'h51;
    localparam logic [7:0] INST_DIVW  = 8'h52;
    localparam logic [7:0] INST_DIVUW = 8'h53;
    localparam logic [7:0] INST_REM   = 8'h54;
    localparam logic [7:0] INST_REMU  = 8'h55;
    localparam logic [7:0] INST_REMW  = 8'h56;
    localparam logic [7:0] INST_REMUW = 8'h57;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  inst_opcode;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        div_start;
    logic        div_kill;
    logic [63:0] div_op1;
    logic [63:0] div_op2;
    logic        div_done;
    logic [63:0] div_quot;
    logic [63:0] div_rem;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [63:0] exp_q[$];

    div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inst_opcode (inst_opcode),
        .src1        (src1),
        .src2        (src2),
        .flush       (flush),
        .div_start   (div_start),
        .div_kill    (div_kill),
        .div_op1     (div_op1),
        .div_op2     (div_op2),
        .div_done    (div_done),
        .div_quot    (div_quot),
        .div_rem     (div_rem),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, out_data);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".data"}, out_data, e);
            $display("txn %s: out_data %h expected %h", tag, out_data, e);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".in_ready"},  {63'd0, in_ready},  64'd1);
        check({tag, ".out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, ".out_data"},  out_data,           64'd0);
        check({tag, ".div_start"}, {63'd0, div_start}, 64'd0);
        check({tag, ".div_kill"},  {63'd0, div_kill},  64'd0);
        check({tag, ".div_op1"},   div_op1,            64'd0);
        check({tag, ".div_op2"},   div_op2,            64'd0);
    endtask

    // Presents one request for one edge; afterwards we are in cycle t+1.
    task automatic issue(input logic [7:0] op, input logic [63:0] s1, input logic [63:0] s2,
                         input bit push, input logic [63:0] exp);
        if (push) exp_q.push_back(exp);
        inst_opcode = op;
        src1        = s1;
        src2        = s2;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
    endtask

    // Divider model: checks the start pulse and operands, then answers after lat cycles.
    task automatic serve(input string tag, input int lat, input logic [63:0] e1, input logic [63:0] e2);
        @(negedge clk);
        check({tag, ".start"}, {63'd0, div_start}, 64'd1);
        check({tag, ".op1"}, div_op1, e1);
        check({tag, ".op2"}, div_op2, e2);
        repeat (lat) begin
            @(posedge clk);
            #1;
        end
        div_done = 1'b1;
        div_quot = e1 / e2;
        div_rem  = e1 % e2;
        @(negedge clk);
        check({tag, ".busy"}, {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        div_done = 1'b0;
        div_quot = 64'd0;
        div_rem  = 64'd0;
        @(negedge clk);
        check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        check_result(tag);
    endtask

    task automatic special(input string tag);
        @(negedge clk);
        check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, ".nostart"}, {63'd0, div_start}, 64'd0);
        check_result(tag);
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, ".out_valid_drop"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        inst_opcode = 8'h00;
        src1        = 64'd0;
        src2        = 64'd0;
        flush       = 1'b0;
        div_done    = 1'b0;
        div_quot    = 64'd0;
        div_rem     = 64'd0;
        out_ready   = 1'b0;

        #12;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        issue(INST_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
        serve("div_neg", 64, 64'd20, 64'd3);
        retire("div_neg");

        issue(INST_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        serve("rem_neg", 5, 64'd20, 64'd3);
        retire("rem_neg");

        issue(INST_REMU, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b1, 64'd2);
        serve("remu", 5, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
        retire("remu");

        issue(INST_DIVW, 64'hABCD_0000_FFFF_FFF9, 64'h5555_5555_0000_0002, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFD);
        serve("divw", 3, 64'd7, 64'd2);
        retire("divw");

        issue(INST_DIVU, 64'd7, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        special("divu_by0");
        retire("divu_by0");

        issue(INST_REMU, 64'd7, 64'd0, 1'b1, 64'd7);
        special("remu_by0");
        retire("remu_by0");

        issue(INST_DIVW, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1,
              64'hFFFF_FFFF_8000_0000);
        special("divw_ovf");
        retire("divw_ovf");

        issue(INST_REMW, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 64'd0);
        special("remw_ovf");
        retire("remw_ovf");

        issue(INST_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'h8000_0000_0000_0000);
        special("div_ovf");
        retire("div_ovf");

        // Flush in the third CALC cycle, then a stale done that must be ignored.
        issue(INST_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b0, 64'd0);
        @(negedge clk);
        check("flush.kill_idle", {63'd0, div_kill}, 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush.kill", {63'd0, div_kill}, 64'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        div_done = 1'b1;
        div_quot = 64'd6;
        div_rem  = 64'd2;
        @(negedge clk);
        check("flush.idle", {63'd0, in_ready}, 64'd1);
        check("flush.kill_off", {63'd0, div_kill}, 64'd0);
        @(posedge clk);
        #1;
        div_done = 1'b0;
        @(negedge clk);
        check("flush.stale_done", {63'd0, out_valid}, 64'd0);
        check("flush.still_idle", {63'd0, in_ready}, 64'd1);
        $display("txn flush: in-flight DIV abandoned");

        // A flush alongside a request accepts nothing.
        inst_opcode = INST_DIVU;
        src1        = 64'd5;
        src2        = 64'd1;
        in_valid    = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("flush_req.in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_req.start", {63'd0, div_start}, 64'd0);
        check("flush_req.valid", {63'd0, out_valid}, 64'd0);
        $display("txn flush_req: request dropped");

        issue(INST_DIVU, 64'd100, 64'd7, 1'b1, 64'd14);
        serve("divu_after_flush", 5, 64'd100, 64'd7);
        retire("divu_after_flush");

        // Backpressure: result must hold while out_ready stays low.
        issue(INST_DIV, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FF72);
        serve("bp", 4, 64'd1000, 64'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp.hold_data", out_data, 64'hFFFF_FFFF_FFFF_FF72);
            check("bp.in_ready", {63'd0, in_ready}, 64'd0);
            check("bp.valid", {63'd0, out_valid}, 64'd1);
        end
        retire("bp");

        // Asynchronous reset during the start cycle of a CALC.
        issue(INST_DIVU, 64'd100, 64'd7, 1'b0, 64'd0);
        #1;
        rst = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.idle", {63'd0, in_ready}, 64'd1);
        $display("txn rst_mid: reset during CALC");

        issue(INST_REMU, 64'd9, 64'd0, 1'b1, 64'd9);
        special("remu_after_rst");
        retire("remu_after_rst");

        check("scoreboard.empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
